instruction_fetcher: RTL

- Consumer side of the program counter interface.
- Takes the current PC address and issues a read to program memory over a valid/ready handshake.
- Holds the returned instruction for the decoder until it is consumed.
- On consumption, pulses `pc_increment` back to the program counter so the next instruction address is presented.
- Sits between the program counter, program memory and the decoder in each core.

---
 rtl/instruction_fetcher_if.sv | 34 +++
 rtl/instruction_fetcher.sv | 113 +++++++++++
 2 files changed

// File: rtl/instruction_fetcher_if.sv
// ----------------------------------------------------------------------------
// instruction_fetcher_if
// Read bus between the instruction fetcher and program memory.
//   mem_read_valid   : fetcher -> memory, a read request is active
//   mem_read_address : fetcher -> memory, address of the active request
//   mem_read_ready   : memory -> fetcher, mem_read_data is returned this cycle
//   mem_read_data    : memory -> fetcher, instruction word
// master = fetcher side, slave = memory side.
// ----------------------------------------------------------------------------
interface instruction_fetcher_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) ();

  logic                  mem_read_valid;
  logic [ADDR_WIDTH-1:0] mem_read_address;
  logic                  mem_read_ready;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data
  );

  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data
  );

endinterface

// File: rtl/instruction_fetcher.sv
// ----------------------------------------------------------------------------
// instruction_fetcher
// Takes the current PC, reads the instruction from program memory over a
// valid/ready handshake, holds it for the decoder and pulses pc_increment
// once the decoder has consumed it.
//   clk, reset           : clock and asynchronous active-high reset
//   pc_in, fetch_start   : address and request from the program counter side
//   flush                : abort the current fetch / drop the held instruction
//   mem                  : program memory read bus (master side)
//   instruction(_valid)  : held instruction word for the decoder
//   instruction_consume  : decoder accepts the held instruction
//   pc_increment         : one-cycle pulse telling the PC to advance
//   busy                 : fetcher is not idle
//   fetch_count          : number of consumed instructions (wraps)
// ----------------------------------------------------------------------------
module instruction_fetcher #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  input  logic                   fetch_start,
  input  logic                   flush,
  instruction_fetcher_if.master  mem,
  output logic [DATA_WIDTH-1:0]  instruction,
  output logic                   instruction_valid,
  input  logic                   instruction_consume,
  output logic                   pc_increment,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    FETCHED
  } state_t;

  state_t                 state_q;
  logic                   read_valid_q;
  logic [ADDR_WIDTH-1:0]  read_address_q;
  logic [DATA_WIDTH-1:0]  instruction_q;
  logic                   instruction_valid_q;
  logic                   pc_increment_q;
  logic [COUNT_WIDTH-1:0] fetch_count_q;
  logic [COUNT_WIDTH-1:0] fetch_count_d;

  // Counter wraps naturally through the fixed-width addition.
  assign fetch_count_d = fetch_count_q + 1'b1;

  // Single registered FSM. pc_increment defaults low every cycle so it can
  // only ever be a one-cycle pulse. Flush is checked first so it overrides
  // ready, consume and fetch_start in every state; the instruction register
  // is deliberately left untouched by a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q             <= IDLE;
      read_valid_q        <= 1'b0;
      read_address_q      <= '0;
      instruction_q       <= '0;
      instruction_valid_q <= 1'b0;
      pc_increment_q      <= 1'b0;
      fetch_count_q       <= '0;
    end else begin
      pc_increment_q <= 1'b0;
      if (flush) begin
        state_q             <= IDLE;
        read_valid_q        <= 1'b0;
        instruction_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (fetch_start) begin
              read_address_q <= pc_in;
              read_valid_q   <= 1'b1;
              state_q        <= REQUEST;
            end
          end
          REQUEST: begin
            if (mem.mem_read_ready) begin
              instruction_q       <= mem.mem_read_data;
              instruction_valid_q <= 1'b1;
              read_valid_q        <= 1'b0;
              state_q             <= FETCHED;
            end
          end
          FETCHED: begin
            if (instruction_consume) begin
              instruction_valid_q <= 1'b0;
              pc_increment_q      <= 1'b1;
              fetch_count_q       <= fetch_count_d;
              state_q             <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign mem.mem_read_valid   = read_valid_q;
  assign mem.mem_read_address = read_address_q;
  assign instruction          = instruction_q;
  assign instruction_valid    = instruction_valid_q;
  assign pc_increment         = pc_increment_q;
  assign fetch_count          = fetch_count_q;
  assign busy                 = (state_q != IDLE);

endmodule
